paralelo_serial: RTL
====================

PARALELO_SERIAL -- requirements
Module: paralelo_serial

Interface
REQ-001 SHALL have parameter N_SYNC, default 4, meaning the number of complete comma bytes (0xBC) sent after reset before data is accepted.
REQ-002 SHALL have parameter COMMA, default 8'hBC, meaning the idle/alignment byte.
REQ-003 SHALL have port clk_32f  input  1  bit clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  reset; one clock, reset synchronous and active-high.
REQ-005 SHALL have port data_in  input  8  parallel byte offered by upstream.
REQ-006 SHALL have port valid_in  input  1  data_in holds a valid byte this cycle.
REQ-007 SHALL have port ready_out  output  1  block can accept a byte this cycle.
REQ-008 SHALL have port data_out  output  1  serial bit stream, MSB first, one bit per clk_32f cycle.
REQ-009 SHALL have port active_out  output  1  sync preamble complete; data path open.

Function
REQ-010 SHALL transfer a byte only on a rising edge where valid_in=1 and ready_out=1.
REQ-011 SHALL hold accepted bytes in a one-entry register (hold, hold_full); ready_out = active_out AND NOT hold_full, registered.
REQ-012 SHALL keep an 8-bit shift register (shreg) and a 3-bit bit counter (bit_cnt, 0..7, wraps 7->0).
REQ-013 SHALL, each non-reset cycle, register data_out <= shreg[7-bit_cnt] and increment bit_cnt.
REQ-014 SHALL, in the cycle bit_cnt=7 (byte boundary), load shreg with hold if hold_full=1 (clearing hold_full), else with COMMA.
REQ-015 SHALL, on acceptance in a boundary cycle while hold_full=0, write data_in into hold; shreg loads COMMA; byte sent in the following byte slot.
REQ-016 SHALL never accept while hold_full=1; no simultaneous load-and-accept.
REQ-017 SHALL implement FSM states SYNC and ACTIVE; reset enters SYNC.
REQ-018 SHALL in SYNC send only COMMA, hold ready_out=0, count completed bytes in sync_cnt (width clog2(N_SYNC+1)).
REQ-019 SHALL transition SYNC->ACTIVE at the boundary completing byte N_SYNC; active_out=1 and ready_out=1 from the next cycle.
REQ-020 SHALL remain in ACTIVE until reset; idle slots carry COMMA.
REQ-021 SHALL transmit data_in=COMMA unmodified (downstream treats it as idle).
REQ-022 SHALL have latency: byte accepted in slot k appears on data_out starting first cycle of slot k+1; MSB 1 cycle after the shreg load.

Reset
REQ-023 SHALL on reset=1 at a rising edge set data_out=0, ready_out=0, active_out=0, bit_cnt=0, sync_cnt=0, hold_full=0, hold=0, shreg=COMMA, state=SYNC.
REQ-024 SHALL on reset mid-byte abort the current byte, discard hold contents, restart the SYNC preamble after reset release.
REQ-025 SHALL, first cycle after reset release, drive data_out=COMMA[7]=1.

Verification
REQ-026 SHALL test preamble: reset 2 cycles then valid_in=0 -> data_out = 1,0,1,1,1,1,0,0 repeated 4 times; active_out rises exactly 32 cycles after release; ready_out=0 throughout.
REQ-027 SHALL test single byte: after active, valid_in=1 data_in=0xA5 for one accepted cycle -> ready_out drops next cycle; next slot bits 1,0,1,0,0,1,0,1; ready_out returns 1 the cycle after hold empties.
REQ-028 SHALL test back-to-back: valid_in held 1 with 0x01,0x02,0x03 -> contiguous slots 0x01,0x02,0x03, no COMMA between; then COMMA when valid_in=0.
REQ-029 SHALL test boundary accept: offer 0x3C exactly at bit_cnt=7 with hold empty -> current next slot COMMA, 0x3C in the slot after.
REQ-030 SHALL test reset mid-byte: assert reset at bit 3 of 0xF0 with 0x0F held -> data_out=0, hold discarded, fresh 4xCOMMA preamble, 0x0F never transmitted.
REQ-031 SHALL test loopback: feed data_out to the downstream serial-parallel receiver (same clk_32f, its 4x clock derived) -> its active asserts and bytes 0xA5,0x01 recovered in order with valid_out.

Source files
------------

// File: rtl/paralelo_serial.sv
// Parallel-to-serial byte transmitter: after reset it sends a comma preamble,
// then shifts accepted bytes out MSB first and fills idle byte slots with COMMA.
module paralelo_serial #(
  parameter int         N_SYNC = 4,
  parameter logic [7:0] COMMA  = 8'hBC
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       data_out,
  output logic       active_out
);

  localparam int            SW        = $clog2(N_SYNC + 1);
  localparam logic [SW-1:0] SYNC_LAST = SW'(N_SYNC - 1);

  typedef enum logic {
    SYNC   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t        state_r, state_s;
  logic [SW-1:0] sync_cnt_r, sync_cnt_s;
  logic [7:0]    shreg_r, shreg_s;
  logic [2:0]    bit_cnt_r, bit_cnt_s;
  logic [7:0]    hold_r, hold_s;
  logic          hold_full_r, hold_full_s;
  logic          data_out_r, data_out_s;
  logic          ready_r, ready_s;
  logic          active_r, active_s;
  logic          boundary_s;
  logic          accept_s;

  // Next-state logic: serializer, hold register, preamble FSM and output flops.
  always_comb begin
    state_s     = state_r;
    sync_cnt_s  = sync_cnt_r;
    shreg_s     = shreg_r;
    hold_s      = hold_r;
    hold_full_s = hold_full_r;
    bit_cnt_s   = bit_cnt_r + 3'd1;
    data_out_s  = shreg_r[3'd7 - bit_cnt_r];
    boundary_s  = (bit_cnt_r == 3'd7);
    accept_s    = valid_in & ready_r;

    if (boundary_s) begin
      if (hold_full_r) begin
        shreg_s     = hold_r;
        hold_full_s = 1'b0;
      end else begin
        shreg_s = COMMA;
      end
    end else begin
      shreg_s = shreg_r;
    end

    // ready_r already excludes a full hold, so accept never collides with a load
    if (accept_s) begin
      hold_s      = data_in;
      hold_full_s = 1'b1;
    end else begin
      hold_s = hold_r;
    end

    case (state_r)
      SYNC: begin
        if (boundary_s) begin
          sync_cnt_s = sync_cnt_r + {{(SW-1){1'b0}}, 1'b1};
          if (sync_cnt_r == SYNC_LAST) begin
            state_s = ACTIVE;
          end else begin
            state_s = SYNC;
          end
        end else begin
          state_s = SYNC;
        end
      end
      ACTIVE: begin
        state_s = ACTIVE;
      end
      default: begin
        state_s = SYNC;
      end
    endcase

    active_s = (state_s == ACTIVE);
    ready_s  = active_s & ~hold_full_s;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_r     <= SYNC;
      sync_cnt_r  <= {SW{1'b0}};
      shreg_r     <= COMMA;
      bit_cnt_r   <= 3'd0;
      hold_r      <= 8'h00;
      hold_full_r <= 1'b0;
      data_out_r  <= 1'b0;
      ready_r     <= 1'b0;
      active_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      sync_cnt_r  <= sync_cnt_s;
      shreg_r     <= shreg_s;
      bit_cnt_r   <= bit_cnt_s;
      hold_r      <= hold_s;
      hold_full_r <= hold_full_s;
      data_out_r  <= data_out_s;
      ready_r     <= ready_s;
      active_r    <= active_s;
    end
  end

  assign data_out   = data_out_r;
  assign ready_out  = ready_r;
  assign active_out = active_r;

endmodule
